// File: rtl/irq_timer.sv
// rtl/irq_timer.sv - memory-mapped down-counting timer with one-shot and auto-reload interrupt modes
// Registers: CTRL {IM, Mode[1:0], Enable}, PRESET, COUNT (read-only); IRQ = irq_flag & IM.
module irq_timer #(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PRESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIN,
  output logic [31:0] DOUT,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  state_t             state, state_next;
  logic [3:0]         ctrl;
  logic [CNT_W-1:0]   preset;
  logic [CNT_W-1:0]   count, count_next;
  logic               irq_flag;
  logic               set_flag, clr_flag, clr_en;
  logic               ctrl_wr, preset_wr;
  logic               enable, auto_reload;

  assign ctrl_wr     = WE && (Addr == 2'd0);
  assign preset_wr   = WE && (Addr == 2'd1);
  assign enable      = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);

  always_comb begin
    state_next = state;
    count_next = count;
    set_flag   = 1'b0;
    clr_flag   = 1'b0;
    clr_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        count_next = preset;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (count != '0) begin
          count_next = count - CNT_W'(1);
        end else begin
          set_flag   = 1'b1;
          state_next = ST_INT;
        end
      end
      ST_INT: begin
        // Software may have dropped Enable while the interrupt was pending.
        if (!auto_reload) begin
          clr_en     = 1'b1;
          state_next = ST_IDLE;
        end else begin
          clr_flag   = 1'b1;
          state_next = enable ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= 4'h0;
      preset   <= RESET_PRESET[CNT_W-1:0];
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      // Bus writes take priority over the FSM's own update of CTRL.
      if (ctrl_wr)     ctrl    <= DIN[3:0];
      else if (clr_en) ctrl[0] <= 1'b0;
      if (preset_wr) preset <= DIN[CNT_W-1:0];
      if (ctrl_wr)       irq_flag <= 1'b0;
      else if (set_flag) irq_flag <= 1'b1;
      else if (clr_flag) irq_flag <= 1'b0;
    end
  end

  always_comb begin
    DOUT = 32'h0;
    case (Addr)
      2'd0:    DOUT = {28'h0, ctrl};
      2'd1:    DOUT = 32'(preset);
      2'd2:    DOUT = 32'(count);
      default: DOUT = 32'h0;
    endcase
  end

  assign IRQ = irq_flag & ctrl[3];

endmodule
